// File: rtl/acc_adder_n_pkg.sv
// Shared definitions for the multi-operand accumulator: state encoding and
// default operand/count widths.
package acc_adder_n_pkg;

  localparam int N_DEF     = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_adder_n_if.sv
// Job control, operand stream and result stream of the accumulator.
interface acc_adder_n_if
  import acc_adder_n_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic                 start;
  logic [LEN_W-1:0]     len;
  logic                 cin_init;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N+LEN_W-1:0]   out_sum;
  logic                 busy;

  modport master (
    output start, len, cin_init, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  start, len, cin_init, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

// File: rtl/acc_adder_n_full_adder.sv
// Combinational N-bit ripple-carry adder (full_adder_n), one full-adder cell
// per bit with the carry chained from bit 0 upwards.
module full_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/acc_adder_n.sv
// Sequential multi-operand summation around one ripple adder: the low N bits
// accumulate through the adder, carries out are counted in a separate register.
module acc_adder_n
  import acc_adder_n_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  acc_adder_n_if.slave bus
);

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [LEN_W-1:0] acc_hi_q, acc_hi_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             cin_q, cin_d;

  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             accept;

  full_adder_n #(.N(N)) u_add (
    .a    (acc_lo_q),
    .b    (bus.in_data),
    .cin  (cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept = (state_q == ST_ACC) && bus.in_valid;

  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    remain_d = remain_q;
    cin_d    = cin_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_hi_d = '0;
          if (bus.len == '0) begin
            // Empty job: the result is just the initial carry.
            acc_lo_d = {{(N-1){1'b0}}, bus.cin_init};
            cin_d    = 1'b0;
            state_d  = ST_DONE;
          end else begin
            acc_lo_d = '0;
            remain_d = bus.len;
            cin_d    = bus.cin_init;
            state_d  = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_lo_d = add_sum;
          acc_hi_d = acc_hi_q + {{(LEN_W-1){1'b0}}, add_cout};
          cin_d    = 1'b0;
          remain_d = remain_q - ONE;
          if (remain_q == ONE) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      remain_q <= '0;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      remain_q <= remain_d;
      cin_q    <= cin_d;
    end
  end

  // Handshake outputs come from the state register alone.
  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_sum   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_acc_adder_n.sv
// Randomised self-checking bench for acc_adder_n against a plain-arithmetic
// sum-of-operands model.
module tb_acc_adder_n;

  typedef logic [3:0] opq_t[$];

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  acc_adder_n_if #(.N(4), .LEN_W(4)) bus ();

  acc_adder_n #(.N(4), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_sum(input bit c, input opq_t d);
    int s;
    s = int'(c);
    foreach (d[i]) s += int'(d[i]);
    return 8'(s);
  endfunction

  // Runs one job from IDLE; returns the result and the edges from start to out_valid.
  task automatic drive_job(input int l, input bit c, input opq_t d, input bit gaps,
                           output logic [7:0] res, output int edges, output bit timeout);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    bus.start    = 1'b1;
    bus.len      = 4'(l);
    bus.cin_init = c;
    @(negedge clk);
    edges = 1;
    bus.start = 1'b0;
    while (idx < l && cyc < 300) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = d[idx];
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
      edges++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 4'($urandom);
    while (!bus.out_valid && cyc < 300) begin
      @(negedge clk);
      edges++;
      cyc++;
    end
    timeout = !bus.out_valid;
    res     = bus.out_sum;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.cin_init = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.out_sum !== 8'h00) begin failures++; $display("FAIL reset_out_sum got=%h exp=00", bus.out_sum); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    opq_t d;
    logic [7:0] res;
    int edges;
    bit to;
    d = '{4'd3, 4'd5, 4'd7};
    drive_job(3, 1'b0, d, 1'b0, res, edges, to);
    checks += 4;
    if (to) begin failures++; $display("FAIL basic_timeout out_valid never rose"); end
    if (res !== model_sum(1'b0, d)) begin failures++; $display("FAIL basic_sum got=%h exp=%h", res, model_sum(1'b0, d)); end
    if (edges != 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", edges); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b exp=1", bus.busy); end
    release_result();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_release_valid got=%b exp=0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_carry();
    opq_t d;
    logic [7:0] res;
    int edges;
    bit to;
    d = '{4'hF, 4'hF};
    drive_job(2, 1'b1, d, 1'b0, res, edges, to);
    checks += 2;
    if (to) begin failures++; $display("FAIL carry_timeout out_valid never rose"); end
    if (res !== model_sum(1'b1, d)) begin failures++; $display("FAIL carry_sum got=%h exp=%h", res, model_sum(1'b1, d)); end
    release_result();
  endtask

  task automatic test_max_gaps();
    opq_t d;
    logic [7:0] res;
    int edges;
    bit to;
    d = {};
    for (int i = 0; i < 15; i++) d.push_back(4'hF);
    drive_job(15, 1'b1, d, 1'b1, res, edges, to);
    checks += 3;
    if (to) begin failures++; $display("FAIL max_timeout out_valid never rose"); end
    if (res !== model_sum(1'b1, d)) begin failures++; $display("FAIL max_sum got=%h exp=%h", res, model_sum(1'b1, d)); end
    if (edges < 16) begin failures++; $display("FAIL max_latency got=%0d exp>=16", edges); end
    release_result();
  endtask

  task automatic test_hold();
    opq_t d;
    logic [7:0] res;
    logic [7:0] exp;
    int edges;
    int l;
    bit to;
    l = $urandom_range(1, 15);
    d = {};
    for (int i = 0; i < l; i++) d.push_back(4'($urandom));
    exp = model_sum(1'b0, d);
    drive_job(l, 1'b0, d, 1'b0, res, edges, to);
    checks += 1;
    if (to || res !== exp) begin failures++; $display("FAIL hold_sum got=%h exp=%h timeout=%0d", res, exp, to); end
    bus.start = 1'b1; bus.len = 4'd5; bus.cin_init = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'hA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 3;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", k, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", k, bus.out_valid); end
      if (bus.out_sum !== exp) begin failures++; $display("FAIL hold_out_sum cyc=%0d got=%h exp=%h", k, bus.out_sum, exp); end
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    release_result();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_release_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_len0();
    opq_t d;
    logic [7:0] res;
    int edges;
    bit to;
    d = {};
    for (int c = 1; c >= 0; c--) begin
      drive_job(0, 1'(c), d, 1'b0, res, edges, to);
      checks += 2;
      if (to || edges != 1) begin failures++; $display("FAIL len0_latency cin=%0d got=%0d exp=1", c, edges); end
      if (res !== model_sum(1'(c), d)) begin failures++; $display("FAIL len0_sum cin=%0d got=%h exp=%h", c, res, model_sum(1'(c), d)); end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    opq_t d;
    logic [7:0] res;
    logic [7:0] exp;
    int edges;
    int l;
    bit c;
    bit to;
    for (int j = 0; j < 8; j++) begin
      l = $urandom_range(0, 15);
      c = 1'($urandom_range(0, 1));
      d = {};
      for (int i = 0; i < l; i++) d.push_back(4'($urandom));
      exp = model_sum(c, d);
      drive_job(l, c, d, j[0], res, edges, to);
      checks += 1;
      if (to || res !== exp) begin failures++; $display("FAIL b2b_sum job=%0d len=%0d got=%h exp=%h timeout=%0d", j, l, res, exp, to); end
      release_result();
    end
  endtask

  task automatic test_reset_midjob();
    opq_t d;
    logic [7:0] res;
    int edges;
    bit to;
    bus.start = 1'b1; bus.len = 4'd4; bus.cin_init = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'd5;
    @(negedge clk);
    bus.in_data = 4'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    if (bus.out_sum !== 8'h00) begin failures++; $display("FAIL midrst_out_sum got=%h exp=00", bus.out_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d = '{4'd9};
    drive_job(1, 1'b0, d, 1'b0, res, edges, to);
    checks += 2;
    if (to) begin failures++; $display("FAIL midrst_job_timeout out_valid never rose"); end
    if (res !== model_sum(1'b0, d)) begin failures++; $display("FAIL midrst_job_sum got=%h exp=%h", res, model_sum(1'b0, d)); end
    release_result();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry();
    test_max_gaps();
    test_hold();
    test_len0();
    test_back_to_back();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_adder_n.md
# acc_adder_n

Multi-operand accumulator built around the combinational `full_adder_n` ripple adder. It accepts a stream of `len` N-bit operands over a valid/ready input handshake and sums them with an optional initial carry-in. It returns the exact (N+LEN_W)-bit total over a valid/ready output handshake. It sits directly downstream of operand sources and feeds the adder's registered result to consumers, so the combinational adder becomes a sequential, multi-cycle summation stage.

## Interface
- `N`, 4, operand width in bits.
- `LEN_W`, 4, width of the operand count; at most 2^LEN_W−1 operands per job.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begins a job; sampled only in IDLE.
- `len`  in  LEN_W  number of operands in the job; sampled with `start`.
- `cin_init`  in  1  carry-in added once, with the first operand; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts an operand this cycle.
- `in_data`  in  N  operand.
- `out_valid`  out  1  `out_sum` holds the finished result.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  N+LEN_W  total: {carry count, low accumulator}.
- `busy`  out  1  high in ACC and DONE.

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 with `len`≠0: `acc_lo`←0, `acc_hi`←0, `remain`←`len`, `cin_r`←`cin_init`, go to ACC.
  - `start`=1 with `len`=0: `acc_lo`←{0…, `cin_init`}, `acc_hi`←0, go to DONE.
- **ACC**
  - `in_ready`=1.
  - The adder instance computes `acc_lo` + `in_data` + `cin_r` every cycle.
  - On accept (`in_valid`&`in_ready`): `acc_lo`←sum, `acc_hi`←`acc_hi`+cout, `cin_r`←0, `remain`←`remain`−1.
  - If `remain`=1 at accept, go to DONE.
  - No accept means no state change. Gaps in `in_valid` of any length are legal.
- **DONE**
  - `out_valid`=1; `out_sum`={`acc_hi`,`acc_lo`}, held stable.
  - On `out_ready`=1, go to IDLE.
  - `out_valid` does not drop until the consumer takes the result.
- `start` in ACC or DONE is ignored. `len` and `cin_init` are not re-sampled.
- Width rule: each carry out is worth 2^N, so `acc_hi` counts carries. The maximum total, (2^LEN_W−1)(2^N−1)+1, fits in N+LEN_W bits, so the result never wraps.
- Reset (`rst_n`=0 at any time, including mid-job):
  - State→IDLE; `acc_lo`, `acc_hi`, `remain`, `cin_r` all go to 0.
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `busy`=0, asynchronously.
  - The job in progress is discarded.

## Timing
- `out_sum` is driven from registers only; there is no combinational path from `in_data` to `out_sum`.
- `in_ready`, `out_valid` and `busy` are decoded from the state register only. None of them depends combinationally on `in_valid` or `out_ready`.
- Throughput: one operand per cycle while `in_valid` stays high.
- Latency: `out_valid` rises in the cycle after the edge that accepts the last operand.
  - Minimum `start`→`out_valid`: `len`+1 edges.
  - `len`=0: `out_valid` is high after 1 edge.
- DONE→IDLE takes one edge. The next `start` can be taken in the cycle after the handshake edge.
- The adder's critical path is the N-bit ripple chain from the `acc_lo`/`in_data` registers to `acc_lo`. The carry count is a separate LEN_W-bit incrementer.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2);
  - default `N`/`LEN_W` constants.
- One sub-module: the existing `full_adder_n` (parameter N; ports a, b, cin, sum, cout), instantiated once.
- Everything else is FSM, counters and registers in this module.

## Test plan
All cases use N=4, LEN_W=4.
1. `start`, `len`=3, `cin_init`=0, data 3,5,7 back-to-back → `out_valid` one cycle after the third accept; `out_sum`=8'h0F.
2. `len`=2, `cin_init`=1, data F,F → `out_sum`=8'h1F (`acc_hi`=1, `acc_lo`=F).
3. `len`=15, `cin_init`=1, all data F → `out_sum`=8'hE2 (226). `in_valid` toggled randomly; the result must be unchanged.
4. After DONE, hold `out_ready`=0 for 3 cycles with `in_valid`=1 and `start`=1 → `in_ready`=0, `out_sum` stable, `start` ignored. Then `out_ready`=1 → IDLE on the next edge.
5. `len`=0, `cin_init`=1 → `out_valid`=1 after one edge, `out_sum`=8'h01.
6. `rst_n` low after the 2nd accept of a `len`=4 job → all outputs 0 immediately; `busy`=0. A new `len`=1 job with data 9 then gives `out_sum`=8'h09.
